// File: rtl/priority_encoder8_stream.sv
// Registered 8-to-3 priority encoder with request capture: pulses on req build a
// pending set, and one code per accepted valid/ready transfer is emitted from it.
module priority_encoder8_stream #(
  parameter int N         = 8,
  parameter int W         = 3,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         e,
  output logic [W-1:0] y,
  output logic         valid,
  input  logic         ready,
  output logic [N-1:0] pending,
  output logic         overflow
);

  generate
    if (W != $clog2(N)) begin : g_bad_width
      $error("priority_encoder8_stream: W must equal clog2(N)");
    end
  endgenerate

  logic [N-1:0] pending_r;
  logic [W-1:0] y_r;
  logic         valid_r;
  logic         overflow_r;

  logic [W-1:0] win_idx_s;
  logic         free_s;
  logic         load_s;
  logic [N-1:0] grant_mask_s;
  logic [N-1:0] pending_next_s;
  logic         overflow_next_s;

  // Winner search over the registered pending set only; the last hit in scan order wins.
  always_comb begin
    win_idx_s = {W{1'b0}};
    if (MSB_FIRST) begin
      for (int i = 0; i < N; i++) begin
        win_idx_s = pending_r[i] ? W'(i) : win_idx_s;
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        win_idx_s = pending_r[i] ? W'(i) : win_idx_s;
      end
    end
  end

  // Slot/load decision, grant mask and next pending/overflow; a same-cycle req beats the grant clear.
  always_comb begin
    free_s = ~valid_r | ready;
    load_s = free_s & e & (pending_r != {N{1'b0}});
    if (load_s) begin
      grant_mask_s = {{(N-1){1'b0}}, 1'b1} << win_idx_s;
    end else begin
      grant_mask_s = {N{1'b0}};
    end
    pending_next_s  = (pending_r & ~grant_mask_s) | req;
    overflow_next_s = |(req & pending_r & ~grant_mask_s);
  end

  // Output and pending state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_r  <= {N{1'b0}};
      y_r        <= {W{1'b0}};
      valid_r    <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      pending_r  <= pending_next_s;
      overflow_r <= overflow_next_s;
      valid_r    <= load_s | (valid_r & ~ready);
      if (load_s) begin
        y_r <= win_idx_s;
      end else begin
        y_r <= y_r;
      end
    end
  end

  assign y        = y_r;
  assign valid    = valid_r;
  assign pending  = pending_r;
  assign overflow = overflow_r;

endmodule

// File: tb/tb_priority_encoder8_stream.sv
// Directed bench for priority_encoder8_stream: an MSB-first and an LSB-first
// instance share stimulus and are checked against hand-computed values.
module tb_priority_encoder8_stream;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       e;
  logic       ready;

  logic [2:0] y_m, y_l;
  logic       valid_m, valid_l;
  logic [7:0] pending_m, pending_l;
  logic       overflow_m, overflow_l;

  int n_checks;
  int n_errors;

  priority_encoder8_stream #(.N(8), .W(3), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .req(req), .e(e), .y(y_m), .valid(valid_m),
    .ready(ready), .pending(pending_m), .overflow(overflow_m)
  );

  priority_encoder8_stream #(.N(8), .W(3), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .req(req), .e(e), .y(y_l), .valid(valid_l),
    .ready(ready), .pending(pending_l), .overflow(overflow_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst   = 1'b1;
    req   = 8'h00;
    e     = 1'b1;
    ready = 1'b1;
    tick();
    check("rst_valid", 32'(valid_m), 32'd0);
    check("rst_y", 32'(y_m), 32'd0);
    check("rst_pending", 32'(pending_m), 32'h0);
    check("rst_overflow", 32'(overflow_m), 32'd0);
    rst = 1'b0;
    tick();

    // single request
    req = 8'h10;
    tick();
    check("single_pend", 32'(pending_m), 32'h10);
    check("single_valid0", 32'(valid_m), 32'd0);
    req = 8'h00;
    tick();
    check("single_y", 32'(y_m), 32'd4);
    check("single_valid", 32'(valid_m), 32'd1);
    check("single_pend_clr", 32'(pending_m), 32'h00);
    tick();
    check("single_done", 32'(valid_m), 32'd0);
    check("single_yhold", 32'(y_m), 32'd4);

    // priority order, both directions
    req = 8'h85;
    tick();
    req = 8'h00;
    tick();
    check("prio_m0", 32'(y_m), 32'd7);
    check("prio_l0", 32'(y_l), 32'd0);
    check("prio_m0_pend", 32'(pending_m), 32'h05);
    check("prio_l0_pend", 32'(pending_l), 32'h84);
    tick();
    check("prio_m1", 32'(y_m), 32'd2);
    check("prio_l1", 32'(y_l), 32'd2);
    tick();
    check("prio_m2", 32'(y_m), 32'd0);
    check("prio_l2", 32'(y_l), 32'd7);
    check("prio_valid2", 32'({valid_m, valid_l}), 32'd3);
    tick();
    check("prio_end", 32'({valid_m, valid_l}), 32'd0);

    // backpressure
    ready = 1'b0;
    req = 8'h06;
    tick();
    req = 8'h00;
    tick();
    check("bp_y", 32'(y_m), 32'd2);
    check("bp_l_y", 32'(y_l), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_y", 32'(y_m), 32'd2);
      check("bp_hold_valid", 32'(valid_m), 32'd1);
      check("bp_hold_pend", 32'(pending_m), 32'h02);
    end
    ready = 1'b1;
    tick();
    check("bp_next_y", 32'(y_m), 32'd1);
    check("bp_next_valid", 32'(valid_m), 32'd1);
    tick();
    check("bp_end", 32'(valid_m), 32'd0);

    // overflow: duplicate request merges
    e = 1'b0;
    req = 8'h08;
    tick();
    check("ovf_pend", 32'(pending_m), 32'h08);
    check("ovf_none_yet", 32'(overflow_m), 32'd0);
    tick();
    check("ovf_pulse", 32'(overflow_m), 32'd1);
    req = 8'h00;
    tick();
    check("ovf_one_cycle", 32'(overflow_m), 32'd0);
    e = 1'b1;
    tick();
    check("ovf_y", 32'(y_m), 32'd3);
    check("ovf_valid", 32'(valid_m), 32'd1);
    tick();
    check("ovf_once", 32'(valid_m), 32'd0);
    check("ovf_pend_clr", 32'(pending_m), 32'h00);

    // collision with grant: set wins, served twice
    req = 8'h08;
    tick();
    tick();
    check("col_y", 32'(y_m), 32'd3);
    check("col_no_ovf", 32'(overflow_m), 32'd0);
    check("col_pend", 32'(pending_m), 32'h08);
    req = 8'h00;
    tick();
    check("col_y2", 32'(y_m), 32'd3);
    check("col_valid2", 32'(valid_m), 32'd1);
    check("col_pend2", 32'(pending_m), 32'h00);
    tick();
    check("col_end", 32'(valid_m), 32'd0);

    // enable gating then streaming
    e = 1'b0;
    req = 8'hFF;
    tick();
    req = 8'h00;
    tick();
    check("en_pend", 32'(pending_m), 32'hFF);
    check("en_valid0", 32'(valid_m), 32'd0);
    e = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("en_stream_m", 32'(y_m), 32'(7 - i));
      check("en_stream_l", 32'(y_l), 32'(i));
      check("en_stream_v", 32'(valid_m), 32'd1);
    end
    tick();
    check("en_end", 32'(valid_m), 32'd0);

    // async reset mid-transfer
    ready = 1'b0;
    req = 8'h80;
    tick();
    req = 8'h5A;
    tick();
    req = 8'h00;
    tick();
    check("mid_valid", 32'(valid_m), 32'd1);
    check("mid_pend", 32'(pending_m), 32'h5A);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(valid_m), 32'd0);
    check("arst_y", 32'(y_m), 32'd0);
    check("arst_pend", 32'(pending_m), 32'h00);
    check("arst_ovf", 32'(overflow_m), 32'd0);
    rst = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
